// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - load/store unit: CPU access to word-aligned memory req/ack with byte enables
// Optional LSU_TIMEOUT_EN: abandons a BUSY access after TIMEOUT_CYCLES cycles without mem_ack.
module lsu_ctrl #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    input  logic                  req_we,
    input  logic [2:0]            funct3,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  ready,
    output logic                  done,
    output logic                  err,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [3:0]            mem_be,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  we_q, we_d;
    logic [2:0]            f3_q, f3_d;
    logic [1:0]            off_q, off_d;
    logic                  ready_q, ready_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  mem_req_q, mem_req_d;
    logic                  mem_we_q, mem_we_d;
    logic [3:0]            mem_be_q, mem_be_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                  tmo_hit;

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // Last permitted BUSY cycle: the count reaches TIMEOUT_CYCLES if this one also lacks an ack.
    assign tmo_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    // Request decode, evaluated on the incoming request in IDLE.
    logic                  legal;
    logic                  aligned;
    logic [3:0]            be_new;
    logic [DATA_WIDTH-1:0] wdata_new;

    always_comb begin
        if (req_we) begin
            legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
        end else begin
            legal = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
        end
        case (funct3[1:0])
            2'b01:   aligned = ~addr[0];
            2'b10:   aligned = (addr[1:0] == 2'b00);
            default: aligned = 1'b1;
        endcase
        case (funct3[1:0])
            2'b00:   be_new = 4'b0001 << addr[1:0];
            2'b01:   be_new = 4'b0011 << {addr[1], 1'b0};
            default: be_new = 4'b1111;
        endcase
        case (funct3[1:0])
            2'b00:   wdata_new = {4{wdata[7:0]}};
            2'b01:   wdata_new = {2{wdata[15:0]}};
            default: wdata_new = wdata;
        endcase
    end

    // Lane extraction from the returning word, using the latched offset and width.
    logic [7:0]            lane_b;
    logic [15:0]           lane_h;
    logic [DATA_WIDTH-1:0] load_ext;

    always_comb begin
        case (off_q)
            2'd0:    lane_b = mem_rdata[7:0];
            2'd1:    lane_b = mem_rdata[15:8];
            2'd2:    lane_b = mem_rdata[23:16];
            default: lane_b = mem_rdata[31:24];
        endcase
        lane_h = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (f3_q)
            3'b000:  load_ext = {{24{lane_b[7]}}, lane_b};
            3'b001:  load_ext = {{16{lane_h[15]}}, lane_h};
            3'b010:  load_ext = mem_rdata;
            3'b100:  load_ext = {24'd0, lane_b};
            3'b101:  load_ext = {16'd0, lane_h};
            default: load_ext = '0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        f3_d        = f3_q;
        off_d       = off_q;
        ready_d     = ready_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        rdata_d     = rdata_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
`ifdef LSU_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    f3_d    = funct3;
                    off_d   = addr[1:0];
                    ready_d = 1'b0;
                    if (legal && aligned) begin
                        state_d     = S_BUSY;
                        mem_req_d   = 1'b1;
                        mem_we_d    = req_we;
                        mem_be_d    = be_new;
                        mem_addr_d  = {addr[ADDR_WIDTH-1:2], 2'b00};
                        mem_wdata_d = req_we ? wdata_new : '0;
`ifdef LSU_TIMEOUT_EN
                        cnt_d       = '0;
`endif
                    end else begin
                        state_d = S_RESP;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end
                end
            end
            S_BUSY: begin
                if (mem_ack || tmo_hit) begin
                    state_d     = S_RESP;
                    done_d      = 1'b1;
                    err_d       = ~mem_ack;
                    rdata_d     = (mem_ack && !we_q) ? load_ext : '0;
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_be_d    = '0;
                    mem_addr_d  = '0;
                    mem_wdata_d = '0;
                end
`ifdef LSU_TIMEOUT_EN
                else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            S_RESP: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            we_q        <= 1'b0;
            f3_q        <= 3'b000;
            off_q       <= 2'b00;
            ready_q     <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
`ifdef LSU_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            f3_q        <= f3_d;
            off_q       <= off_d;
            ready_q     <= ready_d;
            done_q      <= done_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
`ifdef LSU_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign ready     = ready_q;
    assign done      = done_q;
    assign err       = err_q;
    assign rdata     = rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_be    = mem_be_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb/tb_lsu_ctrl.sv - table-driven scoreboard bench for lsu_ctrl
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    lsu_ctrl #(
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (32),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_we   (req_we),
        .funct3   (funct3),
        .addr     (addr),
        .wdata    (wdata),
        .ready    (ready),
        .done     (done),
        .err      (err),
        .rdata    (rdata),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_be   (mem_be),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_ack  (mem_ack),
        .mem_rdata(mem_rdata)
    );

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] wd;
        int          waits;
        logic [31:0] mrd;
        logic        acc;
        logic [3:0]  be;
        logic [31:0] maddr;
        logic [31:0] mwd;
        logic        er;
        logic [31:0] rd;
        int          lat;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", n, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd, input int w, input logic [31:0] mrd,
                                input logic acc, input logic [3:0] be, input logic [31:0] ma,
                                input logic [31:0] mwd, input logic er, input logic [31:0] rd);
        vec_t v;
        v.we = we; v.f3 = f3; v.a = a; v.wd = wd; v.waits = w; v.mrd = mrd;
        v.acc = acc; v.be = be; v.maddr = ma; v.mwd = mwd; v.er = er; v.rd = rd;
        v.lat = acc ? w + 2 : 1;
        return v;
    endfunction

    task automatic run(input vec_t v, input int pulse_at);
        vec_t        e;
        logic        seen;
        logic        got;
        logic        ok;
        logic        extra;
        int          busy;
        logic [68:0] snap;
        @(negedge clk);
        chk("ready_idle", ready, 1);
        req_valid = 1'b1; req_we = v.we; funct3 = v.f3; addr = v.a; wdata = v.wd;
        sb.push_back(v);
        @(negedge clk);
        seen = 0; got = 0; ok = 1; busy = 0; snap = '0;
        for (int c = 1; c <= 300 && !got; c++) begin
            req_valid = 1'b0;
            if (done) begin
                e = sb.pop_front();
                chk("latency", c, e.lat);
                chk("err", err, e.er);
                chk("rdata", rdata, e.rd);
                chk("mem_access", seen, e.acc);
                chk("stable_busy", ok, 1);
                got = 1;
            end else begin
                if (ready) ok = 0;
                if (mem_req) begin
                    if (!seen) begin
                        chk("mem_we", mem_we, v.we);
                        chk("mem_be", mem_be, v.be);
                        chk("mem_addr", mem_addr, v.maddr);
                        if (v.we) chk("mem_wdata", mem_wdata, v.mwd);
                        snap = {mem_we, mem_be, mem_addr, mem_wdata};
                        seen = 1;
                    end else if ({mem_we, mem_be, mem_addr, mem_wdata} !== snap) begin
                        ok = 0;
                    end
                    busy++;
                    mem_ack   = (busy == v.waits + 1);
                    mem_rdata = mem_ack ? v.mrd : $urandom();
                    if (busy == pulse_at) begin
                        req_valid = 1'b1; req_we = 1'b0; funct3 = 3'b010; addr = 32'h40;
                    end
                end else begin
                    mem_ack = 1'b0;
                end
                @(negedge clk);
            end
        end
        mem_ack = 1'b0;
        if (!got) begin
            chk("done_timeout", 0, 1);
            void'(sb.pop_front());
        end else begin
            @(negedge clk);
            chk("done_pulse", done, 0);
            chk("ready_back", ready, 1);
            chk("rdata_hold", rdata, e.rd);
            if (pulse_at > 0) begin
                extra = 0;
                for (int k = 0; k < 3; k++) begin
                    if (mem_req || done) extra = 1;
                    @(negedge clk);
                end
                chk("pulse_ignored", extra, 0);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; funct3 = 3'b000;
        addr = '0; wdata = '0; mem_ack = 1'b0; mem_rdata = '0;

        tbl.push_back(mk(0, 3'b010, 32'h10, 0,           0, 32'hDEAD_BEEF, 1, 4'b1111, 32'h10, 0,           0, 32'hDEAD_BEEF));
        tbl.push_back(mk(0, 3'b000, 32'h13, 0,           0, 32'h8012_3456, 1, 4'b1000, 32'h10, 0,           0, 32'hFFFF_FF80));
        tbl.push_back(mk(0, 3'b100, 32'h13, 0,           1, 32'h8012_3456, 1, 4'b1000, 32'h10, 0,           0, 32'h0000_0080));
        tbl.push_back(mk(1, 3'b001, 32'h22, 32'hABCD,    0, 0,             1, 4'b1100, 32'h20, 32'hABCD_ABCD, 0, 0));
        tbl.push_back(mk(0, 3'b010, 32'h05, 0,           0, 0,             0, 4'b0000, 0,      0,           1, 0));
        tbl.push_back(mk(0, 3'b011, 32'h10, 0,           0, 0,             0, 4'b0000, 0,      0,           1, 0));
        tbl.push_back(mk(0, 3'b001, 32'h12, 0,           2, 32'h8001_7FFF, 1, 4'b1100, 32'h10, 0,           0, 32'hFFFF_8001));
        tbl.push_back(mk(0, 3'b101, 32'h12, 0,           0, 32'h8001_7FFF, 1, 4'b1100, 32'h10, 0,           0, 32'h0000_8001));
        tbl.push_back(mk(1, 3'b010, 32'h04, 32'h1234_5678, 1, 0,           1, 4'b1111, 32'h04, 32'h1234_5678, 0, 0));
        tbl.push_back(mk(1, 3'b100, 32'h08, 32'h55,      0, 0,             0, 4'b0000, 0,      0,           1, 0));
        tbl.push_back(mk(0, 3'b001, 32'h03, 0,           0, 0,             0, 4'b0000, 0,      0,           1, 0));
        tbl.push_back(mk(0, 3'b000, 32'h11, 0,           0, 32'h0000_7F00, 1, 4'b0010, 32'h10, 0,           0, 32'h0000_007F));
        tbl.push_back(mk(1, 3'b000, 32'h3E, 32'h77,      3, 0,             1, 4'b0100, 32'h3C, 32'h7777_7777, 0, 0));

        repeat (2) @(negedge clk);
        chk("rst_ready", ready, 1);
        chk("rst_done_err", {done, err}, 0);
        chk("rst_mem", {mem_req, mem_we, mem_be}, 0);
        chk("rst_data", mem_addr | mem_wdata | rdata, 0);
        rst_n = 1'b1;

        foreach (tbl[i]) run(tbl[i], 0);

        // sb with a 5-cycle wait and a stray request pulse during the wait
        run(mk(1, 3'b000, 32'h01, 32'hA5, 5, 0, 1, 4'b0010, 32'h00, 32'hA5A5_A5A5, 0, 0), 3);

        // reset while BUSY abandons the access immediately
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; funct3 = 3'b000; addr = 32'h01; wdata = 32'hA5;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_rst_req", mem_req, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_req", mem_req, 0);
        chk("rst_mid_ready", ready, 1);
        chk("rst_mid_be", mem_be, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run(tbl[0], 0);

`ifdef LSU_TIMEOUT_EN
        begin
            vec_t t;
            t = mk(0, 3'b010, 32'h30, 0, 1000, 0, 1, 4'b1111, 32'h30, 0, 1, 0);
            t.lat = 5;
            run(t, 0);
            run(mk(0, 3'b010, 32'h30, 0, 3, 32'h1122_3344, 1, 4'b1111, 32'h30, 0, 0, 32'h1122_3344), 0);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store unit: the initiator side of the CPU data-memory interface.
- Accepts one load/store from the execute stage and converts it to a word-aligned memory request with byte enables over a req/ack handshake.
- Returns load data sign- or zero-extended per funct3.
- Sits between the datapath (ALU address, rs2 store data) and the data memory or bus; it lets the core stall on multi-cycle memories.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, data word width (fixed at 32; byte-lane logic assumes 4 lanes).
- TIMEOUT_CYCLES, 255, maximum wait cycles for mem_ack (used only with LSU_TIMEOUT_EN).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  CPU request strobe.
- req_we  input  1  1 = store, 0 = load.
- funct3  input  3  RV32I width/sign code: 000 lb/sb, 001 lh/sh, 010 lw/sw, 100 lbu, 101 lhu.
- addr  input  ADDR_WIDTH  byte address.
- wdata  input  DATA_WIDTH  store data (rs2).
- ready  output  1  high in IDLE; a request is accepted only when ready & req_valid.
- done  output  1  one-cycle completion pulse.
- err  output  1  valid with done: misaligned, illegal funct3, or timeout.
- rdata  output  DATA_WIDTH  extended load data, valid with done.
- mem_req  output  1  memory request, held until acknowledged.
- mem_we  output  1  write enable.
- mem_be  output  4  byte enables.
- mem_addr  output  ADDR_WIDTH  word-aligned address {addr[31:2],2'b00}.
- mem_wdata  output  DATA_WIDTH  lane-replicated store data.
- mem_ack  input  1  memory completion; on a read it qualifies mem_rdata.
- mem_rdata  input  DATA_WIDTH  read word.

Behaviour:
- States:
  - IDLE: ready=1. On req_valid, latch we/funct3/addr/wdata.
  - Legal and aligned request: go to BUSY.
  - Otherwise: go to RESP with err=1 and no memory access.
  - BUSY: mem_req=1, and all mem_* outputs are stable. Ack sampled high: go to RESP; for loads, the extracted lane is registered into rdata.
  - RESP: done=1 for exactly one cycle, then go to IDLE.
- Latency:
  - Accept at edge T; mem_req is high in cycle T+1.
  - If ack arrives in T+1, done is high in T+2. Minimum is 2 cycles, plus one per wait cycle.
- Misaligned:
  - h accesses with addr[0]=1 are misaligned.
  - w accesses with addr[1:0]≠0 are misaligned.
- Illegal funct3:
  - Loads: 011, 110, 111 are illegal.
  - Stores: any funct3 other than 000, 001, 010 is illegal.
- Byte enables:
  - sb: be = 4'b0001 << addr[1:0].
  - sh: be = 4'b0011 << {addr[1],1'b0}.
  - sw: be = 4'b1111.
  - Loads drive the same be pattern with mem_we=0.
- Store data: sb uses {4{wdata[7:0]}}, sh uses {2{wdata[15:0]}}, sw uses wdata.
- Load extraction:
  - Select the byte or halfword from mem_rdata by addr[1:0].
  - lb/lh: sign-extend from the lane MSB. lbu/lhu: zero-extend. lw: pass through.
- rdata hold rules:
  - rdata holds its value until the next load completes.
  - Stores and error completions drive rdata=0.
- Handshake rules:
  - req_valid is ignored when ready=0.
  - mem_ack is ignored outside BUSY.
  - A request is not re-accepted in the RESP cycle.
- Reset (including mid-transaction): state is forced to IDLE immediately. Outputs return to reset values and any outstanding request is abandoned.
- Reset values: ready=1; done, err, mem_req, mem_we = 0; mem_be=0; mem_addr, mem_wdata, rdata = 0.

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- When defined:
  - An 8-bit-minimum counter clears on entry to BUSY and increments each BUSY cycle without ack.
  - When it reaches TIMEOUT_CYCLES, mem_req drops and the block enters RESP with err=1 and rdata=0.
  - An ack in the same cycle as the timeout wins, and the transfer completes normally.
- When undefined: no counter exists, and BUSY waits indefinitely for mem_ack.

Test Plan:
- lw, addr=0x0000_0010, ack after 0 waits, mem_rdata=0xDEAD_BEEF:
  - mem_addr=0x10, be=1111, we=0.
  - done two cycles after accept, rdata=0xDEAD_BEEF, err=0.
- lb / lbu at addr=0x13, mem_rdata=0x8012_3456:
  - be=1000 in both cases.
  - lb: rdata=0xFFFF_FF80. lbu: rdata=0x0000_0080.
- sh at addr=0x22 with wdata=0x0000_ABCD:
  - mem_we=1, be=1100, mem_wdata=0xABCD_ABCD, mem_addr=0x20.
  - done with rdata=0.
- lw at addr=0x05:
  - mem_req never asserts; done+err one cycle after accept.
  - Repeat with funct3=011: same result.
- sb at addr=0x01, ack delayed 5 cycles:
  - mem_req and outputs stable for 6 cycles; ready=0 throughout.
  - A req_valid pulse during the wait is ignored.
  - Assert rst_n=0 mid-wait in a second run: mem_req falls immediately and ready=1.
- With LSU_TIMEOUT_EN and TIMEOUT_CYCLES=4, lw with no ack:
  - done+err after 4 BUSY cycles.
  - A second run with ack on the 4th BUSY cycle completes with err=0.
